// File: rtl/pulse_counter_pkg.sv
// Shared types and constants for the push-button pulse counter.
package pulse_counter_pkg;

    // Behaviour at the count limits.
    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Depth of the metastability synchroniser on each button.
    localparam int SYNC_STAGES = 2;

    // Default number of stable synchronised samples to accept a level change.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/pulse_counter_n_debounce_pulse.sv
// One button input path: invert, synchronise, debounce, then emit a single
// pulse for each accepted press. Releases never pulse.
module debounce_pulse
    import pulse_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic n_in,
    output logic pulse
);

    localparam int SC_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   deb;
    logic                   deb_q;
    logic [SC_W-1:0]        sc;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; the button is inverted so 1 means "pressed".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ~n_in};
        end
    end

    // Accept a new level only after it has differed from deb for
    // DEBOUNCE_CYCLES consecutive samples; any return to deb restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= 1'b0;
            sc  <= '0;
        end else if (s == deb) begin
            sc <= '0;
        end else if (sc == SC_LAST) begin
            deb <= s;
            sc  <= '0;
        end else begin
            sc <= sc + 1'b1;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q <= 1'b0;
        end else begin
            deb_q <= deb;
        end
    end

    assign pulse = deb & ~deb_q;

endmodule

// File: rtl/pulse_counter_n.sv
// Up/down event counter fed by two debounced active-low buttons, with
// synchronous clamped load, boundary flags and a one-cycle wrap pulse.
module pulse_counter_n
    import pulse_counter_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int MAX_COUNT       = 2**WIDTH - 1,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SATURATE        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             n_up,
    input  logic             n_down,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_min,
    output logic             at_max,
    output logic             wrap_evt
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
    localparam cnt_mode_e        MODE   = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

    logic             up_p;
    logic             down_p;
    logic [WIDTH-1:0] load_clamped;

    debounce_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up (
        .clk   (clk),
        .reset (reset),
        .n_in  (n_up),
        .pulse (up_p)
    );

    debounce_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_down (
        .clk   (clk),
        .reset (reset),
        .n_in  (n_down),
        .pulse (down_p)
    );

    // Loads above the limit are clamped to the limit.
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // Counter update: load beats pulses, simultaneous pulses cancel,
    // then a single pulse steps, wraps or saturates at the limits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            wrap_evt <= 1'b0;
        end else begin
            wrap_evt <= 1'b0;
            if (load_en) begin
                count <= load_clamped;
            end else if (up_p && down_p) begin
                count <= count;
            end else if (up_p) begin
                if (count < MAX_V) begin
                    count <= count + 1'b1;
                end else if (MODE == CNT_WRAP) begin
                    count    <= '0;
                    wrap_evt <= 1'b1;
                end
            end else if (down_p) begin
                if (count > '0) begin
                    count <= count - 1'b1;
                end else if (MODE == CNT_WRAP) begin
                    count    <= MAX_V;
                    wrap_evt <= 1'b1;
                end
            end
        end
    end

    assign at_min = (count == '0);
    assign at_max = (count == MAX_V);

endmodule

// File: tb/tb_pulse_counter_n.sv
// Directed bench for pulse_counter_n: a wrapping and a saturating instance
// share the same buttons and load strobe; expected counts come from a small
// model and flow through a scoreboard queue.
module tb_pulse_counter_n;

    localparam int W   = 4;
    localparam int MAX = 9;
    localparam int DC  = 4;

    logic         clk;
    logic         reset;
    logic         n_up;
    logic         n_down;
    logic         load_en;
    logic [W-1:0] load_val;

    logic [W-1:0] count_w, count_s;
    logic         at_min_w, at_max_w, wrap_evt_w;
    logic         at_min_s, at_max_s, wrap_evt_s;

    int n_vec;
    int n_err;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_w, m_s;

    pulse_counter_n #(
        .WIDTH(W), .MAX_COUNT(MAX), .DEBOUNCE_CYCLES(DC), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .reset(reset), .n_up(n_up), .n_down(n_down),
        .load_en(load_en), .load_val(load_val),
        .count(count_w), .at_min(at_min_w), .at_max(at_max_w), .wrap_evt(wrap_evt_w)
    );

    pulse_counter_n #(
        .WIDTH(W), .MAX_COUNT(MAX), .DEBOUNCE_CYCLES(DC), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .reset(reset), .n_up(n_up), .n_down(n_down),
        .load_en(load_en), .load_val(load_val),
        .count(count_s), .at_min(at_min_s), .at_max(at_max_s), .wrap_evt(wrap_evt_s)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Record the model state as the expected output of the stimulus just driven.
    task automatic expect_counts();
        exp_q.push_back(m_w);
        exp_q.push_back(m_s);
    endtask

    // Pop expected counts and compare counts and boundary flags of both instances.
    task automatic chk_counts(input string tag);
        logic [W-1:0] ew, es;
        if (exp_q.size() < 2) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, observed %0d entries expected 2", tag, exp_q.size());
            return;
        end
        ew = exp_q.pop_front();
        es = exp_q.pop_front();
        chk({tag, "/count_w"}, 8'(count_w), 8'(ew));
        chk({tag, "/count_s"}, 8'(count_s), 8'(es));
        chk({tag, "/at_min_w"}, 8'(at_min_w), 8'(ew == 0));
        chk({tag, "/at_max_w"}, 8'(at_max_w), 8'(ew == W'(MAX)));
        chk({tag, "/at_min_s"}, 8'(at_min_s), 8'(es == 0));
        chk({tag, "/at_max_s"}, 8'(at_max_s), 8'(es == W'(MAX)));
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        tick();
        load_en  = 1'b0;
        m_w = (v > W'(MAX)) ? W'(MAX) : v;
        m_s = m_w;
        expect_counts();
    endtask

    task automatic release_all();
        n_up   = 1'b1;
        n_down = 1'b1;
        repeat (12) tick();
    endtask

    // Directed stimulus sequence.
    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        n_up     = 1'b1;
        n_down   = 1'b1;
        load_en  = 1'b0;
        load_val = '0;
        m_w      = '0;
        m_s      = '0;

        // Reset state.
        repeat (2) tick();
        expect_counts();
        chk_counts("reset");
        chk("reset/wrap_w", 8'(wrap_evt_w), 8'd0);
        #2 reset = 1'b0;
        repeat (10) tick();

        // Single long press: exactly one count, at edge 6.
        n_up = 1'b0;
        repeat (6) tick();
        expect_counts();
        chk_counts("press_edge5");
        tick();
        m_w = 1; m_s = 1;
        expect_counts();
        chk_counts("press_edge6");
        repeat (13) tick();
        expect_counts();
        chk_counts("press_held");
        release_all();

        // Three-cycle glitch is rejected.
        n_up = 1'b0;
        repeat (3) tick();
        n_up = 1'b1;
        repeat (12) tick();
        expect_counts();
        chk_counts("glitch");

        // Real press, then bouncing release: one count only.
        n_up = 1'b0;
        repeat (8) tick();
        m_w = 2; m_s = 2;
        for (int i = 0; i < 6; i++) begin
            n_up = i[0] ? 1'b0 : 1'b1;
            tick();
        end
        release_all();
        expect_counts();
        chk_counts("bounce_release");

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #3 reset = 1'b1;
        #1;
        m_w = 0; m_s = 0;
        expect_counts();
        chk_counts("async_reset");
        chk("async_reset/wrap_w", 8'(wrap_evt_w), 8'd0);
        chk("async_reset/wrap_s", 8'(wrap_evt_s), 8'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();

        // Up at the limit: wrap instance wraps with a one-cycle pulse, saturate holds.
        do_load(4'd9);
        chk_counts("load9");
        n_up = 1'b0;
        repeat (7) tick();
        m_w = 0; m_s = 9;
        expect_counts();
        chk_counts("up_at_max");
        chk("up_at_max/wrap_w", 8'(wrap_evt_w), 8'd1);
        chk("up_at_max/wrap_s", 8'(wrap_evt_s), 8'd0);
        tick();
        chk("up_at_max/wrap_w_clear", 8'(wrap_evt_w), 8'd0);
        release_all();

        // Down at zero on the wrap instance; saturate instance just decrements.
        n_down = 1'b0;
        repeat (7) tick();
        m_w = 9; m_s = 8;
        expect_counts();
        chk_counts("down_at_min");
        chk("down_at_min/wrap_w", 8'(wrap_evt_w), 8'd1);
        chk("down_at_min/wrap_s", 8'(wrap_evt_s), 8'd0);
        release_all();

        // Both at zero: wrap instance wraps, saturate instance holds.
        do_load(4'd0);
        chk_counts("load0");
        n_down = 1'b0;
        repeat (7) tick();
        m_w = 9; m_s = 0;
        expect_counts();
        chk_counts("down_at_zero");
        chk("down_at_zero/wrap_w", 8'(wrap_evt_w), 8'd1);
        chk("down_at_zero/wrap_s", 8'(wrap_evt_s), 8'd0);
        release_all();

        // Load above the limit clamps.
        do_load(4'd12);
        chk_counts("load_clamp");
        chk("load_clamp/wrap_w", 8'(wrap_evt_w), 8'd0);

        // Load in the same cycle as an up pulse: the load wins.
        n_up = 1'b0;
        repeat (6) tick();
        do_load(4'd3);
        chk_counts("load_vs_pulse");
        repeat (3) tick();
        expect_counts();
        chk_counts("load_vs_pulse_after");
        release_all();

        // Aligned up and down presses cancel.
        n_up   = 1'b0;
        n_down = 1'b0;
        repeat (10) tick();
        expect_counts();
        chk_counts("aligned");
        release_all();
        expect_counts();
        chk_counts("aligned_release");

        // Reset during debounce discards the in-flight press.
        n_up = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b1;
        tick();
        n_up = 1'b1;
        tick();
        reset = 1'b0;
        repeat (12) tick();
        m_w = 0; m_s = 0;
        expect_counts();
        chk_counts("reset_mid_debounce");

        // Button held through reset release counts once, at edge 6 after release.
        n_up  = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (7) tick();
        m_w = 1; m_s = 1;
        expect_counts();
        chk_counts("held_through_reset");
        repeat (15) tick();
        expect_counts();
        chk_counts("held_indefinitely");
        release_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_counter_n.md
Name: pulse_counter_n

Overview:
Parametrised up/down event counter driven by two active-low push-buttons.
- Each button goes through its own synchroniser, debouncer and press-edge detector, so one press is one count.
- Configurable width, modulo limit and debounce length; selectable wrap or saturate mode.
- Supports synchronous load, boundary flags and a wrap event pulse.
- Sits between the board buttons and downstream control logic (ALU operation selection, display index).

Parameters:
- WIDTH, 4: counter width in bits; must be >= 1.
- MAX_COUNT, 2**WIDTH-1: highest count value; must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a level change; must be >= 1.
- SATURATE, 0: 0 = wrap at the limits, 1 = hold at the limits.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- n_up  in  1  asynchronous active-low increment button.
- n_down  in  1  asynchronous active-low decrement button.
- load_en  in  1  synchronous load strobe, active-high.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count.
- at_min  out  1  high when count == 0.
- at_max  out  1  high when count == MAX_COUNT.
- wrap_evt  out  1  one-cycle pulse when the count wraps.

Behaviour:
- Reset (async assert): count=0, wrap_evt=0, at_min=1, at_max=0. All synchroniser flops, debounced levels, stability counters and edge registers return to the "released" state.
- Input path, per button:
  - Invert the input, then pass it through a 2-flop synchroniser to give the sample s.
  - Debounced level deb and stability counter sc, sized $clog2(DEBOUNCE_CYCLES+1).
  - While s == deb: sc = 0.
  - While s != deb: sc increments each cycle. On the cycle where sc == DEBOUNCE_CYCLES-1 and s != deb: deb <= s and sc <= 0.
  - Press pulse p = deb & ~deb_q, where deb_q is deb registered. p is high for exactly one cycle per accepted press.
  - Releases produce no pulse.
- Latency: take edge 0 as the first rising edge that samples the button low, with the button held low.
  - deb rises at edge 1+DEBOUNCE_CYCLES.
  - count updates at edge 2+DEBOUNCE_CYCLES (edge 6 at the default).
- Glitch rejection: any low excursion shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse. Bounce during release produces no pulse.
- Update priority on each edge:
  1. load_en=1: count <= min(load_val, MAX_COUNT); wrap_evt <= 0. Any same-cycle pulses are discarded.
  2. up pulse and down pulse together: no change.
  3. up pulse: if count < MAX_COUNT, count+1. If count == MAX_COUNT: SATURATE=0 gives count <= 0 and wrap_evt <= 1; SATURATE=1 gives no change.
  4. down pulse: if count > 0, count-1. If count == 0: SATURATE=0 gives count <= MAX_COUNT and wrap_evt <= 1; SATURATE=1 gives no change.
  5. Otherwise: hold.
- wrap_evt: registered; defaults to 0 every cycle unless set as above. High in the same cycle the wrapped count is first visible.
- at_min and at_max: combinational decodes of count.
- Arithmetic: all in WIDTH bits; no overflow is possible because of the explicit limit checks.
- Button held through reset deassertion: treated as a fresh press, giving one pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- Reset during debounce: all in-flight state is discarded; no pulse is generated from it.
- Holding a button indefinitely: exactly one count.

Decomposition:
- Package pulse_counter_pkg:
  - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e (mapped from SATURATE).
  - localparam SYNC_STAGES = 2.
  - Default DEBOUNCE_CYCLES constant.
- Sub-module debounce_pulse:
  - Ports: clk, reset, n_in, pulse.
  - Parameter: DEBOUNCE_CYCLES.
  - Contains the synchroniser, debouncer and press-edge detector; instantiated once per button.
- Top level: counter register, priority logic, flags.

Test Plan (WIDTH=4, MAX_COUNT=9, DEBOUNCE_CYCLES=4):
- Reset: assert reset mid-cycle -> count=0, at_min=1, at_max=0, wrap_evt=0 immediately, without waiting for a clock edge.
- Single press: n_up low for 20 cycles -> count goes 0->1 at edge 6 exactly and stays 1; no second increment. Then a 3-cycle low glitch on n_up -> count still 1. Bouncing release -> no change.
- Wrap mode (SATURATE=0): load 9, press up -> count=0 with wrap_evt=1 for one cycle. Press down -> count=9 with wrap_evt=1, at_max=1.
- Saturate mode (SATURATE=1): load 9, press up -> count stays 9, wrap_evt=0. Load 0, press down -> count stays 0.
- Priority and clamp:
  - load_val=12 -> count=9.
  - load_en in the same cycle as an up pulse -> loaded value wins.
  - Aligned up and down presses -> count unchanged.
- Reset mid-debounce: n_up low for 3 cycles, reset pulse, n_up released -> count stays 0. Repeat with n_up held through reset -> count=1 at the 6th edge after reset deassertion.
